// File: rtl/pid_param_sequencer.sv
// Parameter sequencer for a PID core: shadow registers, a glitch-free commit
// sequence aligned to the frame tick, and setpoint slewing toward the target.
module pid_param_sequencer (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_i,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [3:0]         wr_addr_i,
  input  logic [15:0]        wr_data_i,
  output logic               enable_o,
  output logic               clear_o,
  output logic signed [15:0] kp_o,
  output logic signed [15:0] kd_o,
  output logic signed [15:0] ki_o,
  output logic signed [13:0] sp_o,
  output logic [3:0]         alpha_o,
  output logic [4:0]         satwidth_o,
  output logic [13:0]        decimate_o,
  output logic               busy_o,
  output logic               addr_err_o
);

  typedef enum logic [1:0] {IDLE, ARMED, QUIESCE, LOAD} state_t;

  state_t             state_q, state_d;
  logic               clr_q, clr_d;
  logic               addr_err_q, addr_err_d;
  logic [13:0]        cnt_q, cnt_d;

  logic signed [15:0] kp_sh_q, kp_sh_d, kd_sh_q, kd_sh_d, ki_sh_q, ki_sh_d;
  logic signed [13:0] tgt_sh_q, tgt_sh_d;
  logic [3:0]         alpha_sh_q, alpha_sh_d;
  logic [4:0]         sat_sh_q, sat_sh_d;
  logic [13:0]        dec_sh_q, dec_sh_d;
  logic [12:0]        step_sh_q, step_sh_d;

  logic signed [15:0] kp_q, kp_d, kd_q, kd_d, ki_q, ki_d;
  logic signed [13:0] tgt_q, tgt_d, sp_q, sp_d;
  logic [3:0]         alpha_q, alpha_d;
  logic [4:0]         sat_q, sat_d;
  logic [13:0]        dec_q, dec_d;
  logic [12:0]        step_q, step_d;

  logic               wr_fire, tick;
  logic signed [14:0] diff, abs_diff, step_ext;
  logic signed [13:0] step14;

  assign wr_ready_o = (state_q == IDLE);
  assign busy_o     = (state_q != IDLE);
  assign enable_o   = run_i && ((state_q == IDLE) || (state_q == ARMED));
  assign clear_o    = (state_q == LOAD) && clr_q;
  assign addr_err_o = addr_err_q;
  assign kp_o       = kp_q;
  assign kd_o       = kd_q;
  assign ki_o       = ki_q;
  assign sp_o       = sp_q;
  assign alpha_o    = alpha_q;
  assign satwidth_o = sat_q;
  assign decimate_o = dec_q;

  assign wr_fire  = wr_valid_i && wr_ready_o;
  assign tick     = (cnt_q == dec_q);
  assign diff     = {tgt_q[13], tgt_q} - {sp_q[13], sp_q};
  assign abs_diff = diff[14] ? -diff : diff;
  assign step_ext = {2'b00, step_q};
  assign step14   = {1'b0, step_q};

  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    addr_err_d = addr_err_q;
    cnt_d      = tick ? 14'd0 : cnt_q + 14'd1;
    kp_sh_d    = kp_sh_q;
    kd_sh_d    = kd_sh_q;
    ki_sh_d    = ki_sh_q;
    tgt_sh_d   = tgt_sh_q;
    alpha_sh_d = alpha_sh_q;
    sat_sh_d   = sat_sh_q;
    dec_sh_d   = dec_sh_q;
    step_sh_d  = step_sh_q;
    kp_d       = kp_q;
    kd_d       = kd_q;
    ki_d       = ki_q;
    tgt_d      = tgt_q;
    alpha_d    = alpha_q;
    sat_d      = sat_q;
    dec_d      = dec_q;
    step_d     = step_q;
    sp_d       = sp_q;

    if (wr_fire) begin
      case (wr_addr_i)
        4'd0:  kp_sh_d    = wr_data_i;
        4'd1:  kd_sh_d    = wr_data_i;
        4'd2:  ki_sh_d    = wr_data_i;
        4'd3:  tgt_sh_d   = wr_data_i[13:0];
        4'd4:  alpha_sh_d = wr_data_i[3:0];
        4'd5:  sat_sh_d   = wr_data_i[4:0];
        4'd6:  dec_sh_d   = wr_data_i[13:0];
        4'd8:  step_sh_d  = wr_data_i[12:0];
        4'd15: begin
          if (wr_data_i[0]) begin
            state_d = ARMED;
            clr_d   = wr_data_i[1];
          end
        end
        default: addr_err_d = 1'b1;
      endcase
    end

    case (state_q)
      ARMED:   if (tick) state_d = QUIESCE;
      QUIESCE: state_d = LOAD;
      LOAD: begin
        kp_d       = kp_sh_q;
        kd_d       = kd_sh_q;
        ki_d       = ki_sh_q;
        tgt_d      = tgt_sh_q;
        alpha_d    = alpha_sh_q;
        sat_d      = sat_sh_q;
        dec_d      = dec_sh_q;
        step_d     = step_sh_q;
        addr_err_d = 1'b0;
        cnt_d      = 14'd0;
        state_d    = IDLE;
      end
      default: ;
    endcase

    // Slew never overshoots, so the 14-bit add/subtract cannot wrap.
    if (tick && enable_o) begin
      if ((step_q == 13'd0) || (abs_diff <= step_ext))
        sp_d = tgt_q;
      else if (diff[14])
        sp_d = sp_q - step14;
      else
        sp_d = sp_q + step14;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      clr_q      <= 1'b0;
      addr_err_q <= 1'b0;
      cnt_q      <= '0;
      kp_sh_q    <= '0;
      kd_sh_q    <= '0;
      ki_sh_q    <= '0;
      tgt_sh_q   <= '0;
      alpha_sh_q <= '0;
      sat_sh_q   <= 5'd15;
      dec_sh_q   <= '0;
      step_sh_q  <= '0;
      kp_q       <= '0;
      kd_q       <= '0;
      ki_q       <= '0;
      tgt_q      <= '0;
      alpha_q    <= '0;
      sat_q      <= 5'd15;
      dec_q      <= '0;
      step_q     <= '0;
      sp_q       <= '0;
    end else begin
      state_q    <= state_d;
      clr_q      <= clr_d;
      addr_err_q <= addr_err_d;
      cnt_q      <= cnt_d;
      kp_sh_q    <= kp_sh_d;
      kd_sh_q    <= kd_sh_d;
      ki_sh_q    <= ki_sh_d;
      tgt_sh_q   <= tgt_sh_d;
      alpha_sh_q <= alpha_sh_d;
      sat_sh_q   <= sat_sh_d;
      dec_sh_q   <= dec_sh_d;
      step_sh_q  <= step_sh_d;
      kp_q       <= kp_d;
      kd_q       <= kd_d;
      ki_q       <= ki_d;
      tgt_q      <= tgt_d;
      alpha_q    <= alpha_d;
      sat_q      <= sat_d;
      dec_q      <= dec_d;
      step_q     <= step_d;
      sp_q       <= sp_d;
    end
  end

endmodule

// File: tb/tb_pid_param_sequencer.sv
// Directed bench for pid_param_sequencer: commit timing, decimated arming,
// setpoint slewing, clear pulse, address errors and reset abort.
module tb_pid_param_sequencer;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               run_i = 1'b0;
  logic               wr_valid_i = 1'b0;
  logic [3:0]         wr_addr_i = '0;
  logic [15:0]        wr_data_i = '0;
  logic               wr_ready_o, enable_o, clear_o, busy_o, addr_err_o;
  logic signed [15:0] kp_o, kd_o, ki_o;
  logic signed [13:0] sp_o;
  logic [3:0]         alpha_o;
  logic [4:0]         satwidth_o;
  logic [13:0]        decimate_o;

  int checks = 0;
  int errors = 0;
  int nb, nel, ncl;
  int seq_up[5]   = '{3, 6, 9, 10, 10};
  int seq_down[7] = '{7, 4, 1, -2, -5, -8, -10};

  pid_param_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .run_i      (run_i),
    .wr_valid_i (wr_valid_i),
    .wr_ready_o (wr_ready_o),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .enable_o   (enable_o),
    .clear_o    (clear_o),
    .kp_o       (kp_o),
    .kd_o       (kd_o),
    .ki_o       (ki_o),
    .sp_o       (sp_o),
    .alpha_o    (alpha_o),
    .satwidth_o (satwidth_o),
    .decimate_o (decimate_o),
    .busy_o     (busy_o),
    .addr_err_o (addr_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    wr_addr_i  = a;
    wr_data_i  = d;
    wr_valid_i = 1'b1;
    step_clk();
    wr_valid_i = 1'b0;
    $display("write addr=%0d data=0x%04h", a, d);
  endtask

  // Issues a control write, then counts busy, enable-low and clear cycles.
  task automatic commit(input logic [15:0] ctrl, output int b, output int el, output int cl);
    int guard;
    guard = 0;
    b = 0; el = 0; cl = 0;
    wr(4'd15, ctrl);
    while (busy_o && guard < 300) begin
      b++;
      if (!enable_o) el++;
      if (clear_o) cl++;
      step_clk();
      guard++;
    end
    check("commit_done", int'(busy_o), 0);
    $display("commit ctrl=0x%0h busy=%0d enable_low=%0d clear=%0d", ctrl, b, el, cl);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_enable", int'(enable_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_addr_err", int'(addr_err_o), 0);
    check("rst_clear", int'(clear_o), 0);
    check("rst_kp", int'(kp_o), 0);
    check("rst_sp", int'(sp_o), 0);
    check("rst_sat", int'(satwidth_o), 15);
    check("rst_dec", int'(decimate_o), 0);
    rst = 1'b1;
    step_clk();
    check("rst_wr_ready", int'(wr_ready_o), 1);
    run_i = 1'b1;

    // Basic commit with decimate 0.
    wr(4'd0, 16'h3FFF);
    check("kp_shadow_only", int'(kp_o), 0);
    commit(16'h0001, nb, nel, ncl);
    check("c1_busy", nb, 3);
    check("c1_enable_low", nel, 2);
    check("c1_clear", ncl, 0);
    check("c1_kp", int'(kp_o), 16'h3FFF);
    check("c1_enable_idle", int'(enable_o), 1);

    // Control write without commit bit is ignored.
    wr(4'd15, 16'h0002);
    check("ctrl_nocommit_busy", int'(busy_o), 0);

    // Decimate 2: counter cleared in LOAD, commit issued at count 0.
    wr(4'd6, 16'd2);
    commit(16'h0001, nb, nel, ncl);
    check("dec_active", int'(decimate_o), 2);
    commit(16'h0001, nb, nel, ncl);
    check("dec2_busy", nb, 4);
    check("dec2_enable_low", nel, 2);

    // Slew up then down.
    wr(4'd6, 16'd0);
    wr(4'd3, 16'd10);
    wr(4'd8, 16'd3);
    commit(16'h0001, nb, nel, ncl);
    check("slew_start", int'(sp_o), 0);
    foreach (seq_up[i]) begin
      step_clk();
      check($sformatf("slew_up%0d", i), int'(sp_o), seq_up[i]);
    end
    wr(4'd3, 16'hFFF6);
    commit(16'h0001, nb, nel, ncl);
    check("slew_hold", int'(sp_o), 10);
    foreach (seq_down[i]) begin
      step_clk();
      check($sformatf("slew_dn%0d", i), int'(sp_o), seq_down[i]);
    end

    // run_i low freezes the setpoint.
    wr(4'd3, 16'd0);
    commit(16'h0001, nb, nel, ncl);
    run_i = 1'b0;
    repeat (3) step_clk();
    check("freeze_sp", int'(sp_o), -10);
    check("freeze_enable", int'(enable_o), 0);
    run_i = 1'b1;
    step_clk();
    check("resume_sp0", int'(sp_o), -7);
    step_clk();
    check("resume_sp1", int'(sp_o), -4);

    // Clear-on-commit pulse.
    commit(16'h0003, nb, nel, ncl);
    check("clr_pulse", ncl, 1);
    commit(16'h0001, nb, nel, ncl);
    check("clr_none", ncl, 0);

    // Unmapped address.
    wr(4'd9, 16'h1234);
    check("aerr_set", int'(addr_err_o), 1);
    step_clk();
    step_clk();
    check("aerr_hold", int'(addr_err_o), 1);
    check("aerr_kp", int'(kp_o), 16'h3FFF);
    check("aerr_dec", int'(decimate_o), 0);
    check("aerr_sat", int'(satwidth_o), 15);
    commit(16'h0001, nb, nel, ncl);
    check("aerr_cleared", int'(addr_err_o), 0);
    check("aerr_kp_after", int'(kp_o), 16'h3FFF);
    check("aerr_dec_after", int'(decimate_o), 0);
    check("aerr_sp_after", int'(sp_o), 0);

    // Reset while ARMED with a pending shadow kp.
    wr(4'd6, 16'd100);
    commit(16'h0001, nb, nel, ncl);
    wr(4'd0, 16'h0055);
    wr(4'd15, 16'h0001);
    check("armed_busy", int'(busy_o), 1);
    rst   = 1'b0;
    run_i = 1'b0;
    #2;
    check("abort_kp", int'(kp_o), 0);
    check("abort_busy", int'(busy_o), 0);
    check("abort_enable", int'(enable_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step_clk();
    check("abort_wr_ready", int'(wr_ready_o), 1);
    check("abort_busy_rel", int'(busy_o), 0);
    check("abort_enable_rel", int'(enable_o), 0);
    check("abort_dec", int'(decimate_o), 0);
    run_i = 1'b1;
    commit(16'h0001, nb, nel, ncl);
    check("abort_shadow_kp", int'(kp_o), 0);
    check("abort_commit_busy", nb, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pid_param_sequencer.md
PID_PARAM_SEQUENCER -- requirements
Module: pid_param_sequencer

Interface
REQ-001 SHALL have ports in this order (name, direction, width, meaning):
- clk, in, 1: single clock.
- rst, in, 1: reset, asynchronous, active-low.
- run_i, in, 1: operator run request.
- wr_valid_i, in, 1: parameter write strobe.
- wr_ready_o, out, 1: write accepted.
- wr_addr_i, in, 4: register address.
- wr_data_i, in, 16: write data.
- enable_o, out, 1: to pid_core enable_i.
- clear_o, out, 1: one-cycle integrator/state clear pulse.
- kp_o, out, 16 signed: active proportional gain.
- kd_o, out, 16 signed: active derivative gain.
- ki_o, out, 16 signed: active integral gain.
- sp_o, out, 14 signed: slewed setpoint.
- alpha_o, out, 4: active filter coefficient.
- satwidth_o, out, 5: active saturation width.
- decimate_o, out, 14: active decimation.
- busy_o, out, 1: commit in progress.
- addr_err_o, out, 1: sticky unmapped-address flag.

REQ-002 SHALL use the following address map, writes landing in shadow registers (low bits of wr_data_i, upper bits ignored):
- 0 kp, 1 kd, 2 ki, 3 sp target (14b), 4 alpha (4b), 5 satwidth (5b), 6 decimate (14b), 8 sp_step (13b unsigned).
- 15 control: bit0 = commit, bit1 = clear-on-commit.

Function
REQ-003 SHALL complete a write handshake when wr_valid_i && wr_ready_o on a rising edge; wr_ready_o SHALL be 1 only in IDLE.
REQ-004 SHALL accept writes to addresses 7 and 9-14 without changing any register and SHALL set addr_err_o, which holds until the next completed commit.
REQ-005 SHALL generate an internal frame tick from a 14-bit counter: the counter counts 0..decimate_o, the tick is asserted on the cycle the counter equals decimate_o, and the counter then wraps to 0; decimate_o=0 gives a tick every cycle.
REQ-006 SHALL implement FSM states IDLE, ARMED, QUIESCE and LOAD.
REQ-007 SHALL transition IDLE->ARMED on an accepted write to address 15 with bit0=1, latching bit1; a control write with bit0=0 SHALL have no effect.
REQ-008 SHALL transition ARMED->QUIESCE on the first frame tick after entry, not counting a tick on the entry cycle itself.
REQ-009 SHALL spend exactly one cycle in QUIESCE with enable_o=0, then go to LOAD.
REQ-010 SHALL in LOAD (one cycle) copy all shadow registers to the active registers and the sp target register, pulse clear_o if the latched bit1=1, hold enable_o=0, clear addr_err_o and the decimation counter, then return to IDLE.
REQ-011 SHALL drive enable_o = run_i when in IDLE or ARMED and 0 otherwise; busy_o = (state != IDLE).
REQ-012 SHALL not change active outputs outside LOAD, except for sp_o slewing.
REQ-013 SHALL slew sp_o toward the active target on each frame tick while enable_o=1:
- step=0 or |target - sp_o| <= step: sp_o = target.
- otherwise: sp_o moves by ±step toward the target.
- arithmetic in 15-bit signed; no overshoot or wrap.
REQ-014 SHALL freeze sp_o while enable_o=0, including while run_i=0.
REQ-015 SHALL use the new step and target from the first tick after LOAD.
REQ-016 SHALL let run_i deassertion mid-commit leave the FSM sequence unaffected.

Reset
REQ-017 SHALL, on rst low, asynchronously set:
- state IDLE, all counters 0;
- enable_o, clear_o, busy_o and addr_err_o 0; wr_ready_o 1 after release;
- kp, kd, ki, sp target, sp_o, alpha, decimate, sp_step 0 (active and shadow);
- satwidth 5'd15 (active and shadow).
REQ-018 SHALL, when rst is asserted mid-commit, abort the commit with no partial load of active registers.

Verification
REQ-019 The bench SHALL cover:
- Write kp=0x3FFF, then control=0x1 with decimate_o=0 -> enable_o low for QUIESCE and LOAD (2 cycles), kp_o=0x3FFF on the cycle after LOAD, busy_o high 3 cycles total.
- Active decimate=2, commit -> QUIESCE entered on the cycle after the first tick (counter=2).
- sp target 10, step 3, decimate 0 -> sp_o sequence 3, 6, 9, 10, 10; target -10 -> sp_o 7, 4, 1, -2, -5, -8, -10.
- Control=0x3 -> single-cycle clear_o in LOAD; control=0x1 -> no clear_o pulse.
- Write address 9 -> addr_err_o=1 and no register changes; cleared after the next commit.
- rst asserted while ARMED with a shadow kp pending -> kp_o=0, state IDLE, enable_o=0, wr_ready_o=1 after release.
